// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Opcode and FSM state encodings shared by the seq_alu block.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_muldiv
// Description : Iterative shift-add multiplier / restoring divider, 1 bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   res
);

    localparam int CNT_W = $clog2(WIDTH);

    logic               r_busy;
    logic               r_is_div;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_opb;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;

    // {r_acc, r_shift} is the product register for MUL and {rem, quot} for DIV
    always_comb begin
        w_addend    = r_shift[0] ? r_opb : '0;
        w_sum       = {1'b0, r_acc} + {1'b0, w_addend};
        w_rem_sh    = {r_acc, r_shift[WIDTH-1]};
        w_ge        = (w_rem_sh >= {1'b0, r_opb});
        // difference is below the divisor whenever it is used, so WIDTH bits suffice
        w_rem_sub   = w_rem_sh[WIDTH-1:0] - r_opb;
        w_acc_nxt   = w_sum[WIDTH:1];
        w_shift_nxt = {w_sum[0], r_shift[WIDTH-1:1]};
        if (r_is_div) begin
            w_acc_nxt   = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
            w_shift_nxt = {r_shift[WIDTH-2:0], w_ge};
        end
    end

    assign done = r_busy && (r_cnt == CNT_W'(WIDTH-1));
    assign res  = {w_acc_nxt, w_shift_nxt};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_shift  <= '0;
            r_opb    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_is_div <= is_div;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_shift  <= a;
            r_opb    <= b;
        end else if (r_busy) begin
            r_acc   <= w_acc_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU with valid/ready handshakes and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = OP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [OPW-1:0]       op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_zero,
    output logic                 flag_carry,
    output logic                 flag_dbz,
    output logic                 flag_illegal
);

    state_e             r_state;
    state_e             w_state_nxt;

    logic               w_op_hi_zero;
    op_e                w_op;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_iter_div;
    logic               w_start;
    logic               w_md_done;
    logic [2*WIDTH-1:0] w_md_res;

    logic [WIDTH:0]     w_sum_ext;
    logic [WIDTH:0]     w_diff_ext;
    logic [2*WIDTH-1:0] w_sc_result;
    logic               w_sc_carry;
    logic               w_sc_dbz;
    logic               w_sc_illegal;

    logic [2*WIDTH-1:0] r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_dbz;
    logic               r_illegal;

    // Any set bit above the architected opcode field makes the opcode reserved
    generate
        if (OPW > OP_W) begin : g_op_wide
            assign w_op_hi_zero = ~|op[OPW-1:OP_W];
        end else begin : g_op_narrow
            assign w_op_hi_zero = 1'b1;
        end
    endgenerate

    assign w_op          = w_op_hi_zero ? op_e'(op[OP_W-1:0]) : OP_RSVD;
    assign w_accept      = in_valid && (r_state == IDLE);
    assign w_is_mul      = (w_op == OP_MUL);
    assign w_is_iter_div = (w_op == OP_DIV) && (b != '0);
    assign w_start       = w_accept && (w_is_mul || w_is_iter_div);

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .is_div (w_is_iter_div),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .res    (w_md_res)
    );

    always_comb begin
        w_sum_ext    = {1'b0, a} + {1'b0, b};
        w_diff_ext   = {1'b0, a} - {1'b0, b};
        w_sc_result  = '0;
        w_sc_carry   = 1'b0;
        w_sc_dbz     = 1'b0;
        w_sc_illegal = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_sc_result = {{WIDTH{1'b0}}, w_sum_ext[WIDTH-1:0]};
                w_sc_carry  = w_sum_ext[WIDTH];
            end
            OP_SUB: begin
                w_sc_result = {{WIDTH{1'b0}}, w_diff_ext[WIDTH-1:0]};
                w_sc_carry  = w_diff_ext[WIDTH];
            end
            OP_AND:  w_sc_result = {{WIDTH{1'b0}}, a & b};
            OP_OR:   w_sc_result = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  w_sc_result = {{WIDTH{1'b0}}, a ^ b};
            // only reaches the output registers when b == 0
            OP_DIV: begin
                w_sc_result = {a, {WIDTH{1'b1}}};
                w_sc_dbz    = 1'b1;
            end
            OP_RSVD: w_sc_illegal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = MUL;
                    end else if (w_is_iter_div) begin
                        w_state_nxt = DIV;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            MUL, DIV: begin
                if (w_md_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_start) begin
            r_result  <= w_sc_result;
            r_zero    <= (w_sc_result == '0);
            r_carry   <= w_sc_carry;
            r_dbz     <= w_sc_dbz;
            r_illegal <= w_sc_illegal;
        end else if (((r_state == MUL) || (r_state == DIV)) && w_md_done) begin
            r_result  <= w_md_res;
            r_zero    <= (w_md_res == '0);
            r_carry   <= 1'b0;
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign result       = r_result;
    assign flag_zero    = r_zero;
    assign flag_carry   = r_carry;
    assign flag_dbz     = r_dbz;
    assign flag_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2:0]     op = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] result;
    logic           flag_zero;
    logic           flag_carry;
    logic           flag_dbz;
    logic           flag_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH (W),
        .OPW   (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .op           (op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .flag_dbz     (flag_dbz),
        .flag_illegal (flag_illegal)
    );

    // Reference: plain integer arithmetic; flags packed {zero, carry, dbz, illegal}
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] mop,
                         output logic [2*W-1:0] er, output logic [3:0] ef, output int elat);
        int unsigned x, y, t;
        logic ec, ed, ei;
        x = ma; y = mb; t = 0; ec = 0; ed = 0; ei = 0; elat = 1;
        case (mop)
            3'd0: begin t = (x + y) % (1 << W); ec = (x + y) >= (1 << W); end
            3'd1: begin t = (x + (1 << W) - y) % (1 << W); ec = (x < y); end
            3'd2: begin t = x * y; elat = W + 1; end
            3'd3: begin
                if (y == 0) begin
                    t = (x << W) | ((1 << W) - 1); ed = 1;
                end else begin
                    t = ((x % y) << W) | (x / y); elat = W + 1;
                end
            end
            3'd4: t = x & y;
            3'd5: t = x | y;
            3'd6: t = x ^ y;
            default: ei = 1;
        endcase
        er = t[2*W-1:0];
        ef = {(t == 0), ec, ed, ei};
    endtask

    // Issue one operation and wait for out_valid; optionally scramble inputs while busy
    task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic [2:0] sop,
                            input bit garbage, output int lat, output bit rdy_bad);
        @(negedge clk);
        a = sa; b = sb; op = sop; in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (garbage) begin
            a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        rdy_bad = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (in_ready) rdy_bad = 1;
            if (lat >= 40) break;
            if (garbage) begin
                out_ready = 1'($urandom);
                a = W'($urandom); b = W'($urandom); op = 3'($urandom);
            end
        end
        if (in_ready) rdy_bad = 1;
        out_ready = 1'b0;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++; $display("FAIL reset_hs: in_ready,out_valid=%b required 10", {in_ready, out_valid});
        end
        n_cmp++;
        if ({result, flag_zero, flag_carry, flag_dbz, flag_illegal} !== '0) begin
            n_err++; $display("FAIL reset_out: result=%h flags=%b required 0", result,
                              {flag_zero, flag_carry, flag_dbz, flag_illegal});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta [7] = '{8'hF0, 8'h03, 8'h0F, 8'd200, 8'd200, 8'h55, 8'h12};
        logic [W-1:0]   tb [7] = '{8'h20, 8'h05, 8'hF0, 8'd200, 8'd7,   8'h00, 8'h34};
        logic [2:0]     to [7] = '{3'd0,  3'd1,  3'd4,  3'd2,   3'd3,   3'd3,  3'd7};
        logic [2*W-1:0] tr [7] = '{16'h0010, 16'h00FE, 16'h0000, 16'h9C40, 16'h041C, 16'h55FF, 16'h0000};
        logic [2*W-1:0] er;
        logic [3:0]     ef;
        int             elat, lat;
        bit             rdy_bad;
        for (int i = 0; i < 7; i++) begin
            model(ta[i], tb[i], to[i], er, ef, elat);
            start_op(ta[i], tb[i], to[i], 1'b0, lat, rdy_bad);
            n_cmp++;
            if (result !== tr[i]) begin
                n_err++; $display("FAIL dir_result[%0d]: got %h required %h", i, result, tr[i]);
            end
            n_cmp++;
            if ({flag_zero, flag_carry, flag_dbz, flag_illegal} !== ef) begin
                n_err++; $display("FAIL dir_flags[%0d]: got %b required %b", i,
                                  {flag_zero, flag_carry, flag_dbz, flag_illegal}, ef);
            end
            n_cmp++;
            if (lat != elat) begin
                n_err++; $display("FAIL dir_latency[%0d]: got %0d required %0d", i, lat, elat);
            end
            n_cmp++;
            if (rdy_bad) begin
                n_err++; $display("FAIL dir_in_ready[%0d]: got 1 while busy required 0", i);
            end
            finish_op();
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   ra, rb;
        logic [2:0]     ro;
        logic [2*W-1:0] er;
        logic [3:0]     ef;
        int             elat, lat;
        bit             rdy_bad;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            ro = 3'($urandom);
            model(ra, rb, ro, er, ef, elat);
            start_op(ra, rb, ro, 1'b1, lat, rdy_bad);
            n_cmp++;
            if (result !== er) begin
                n_err++; $display("FAIL rnd_result: op=%0d a=%h b=%h got %h required %h", ro, ra, rb, result, er);
            end
            n_cmp++;
            if ({flag_zero, flag_carry, flag_dbz, flag_illegal} !== ef) begin
                n_err++; $display("FAIL rnd_flags: op=%0d a=%h b=%h got %b required %b", ro, ra, rb,
                                  {flag_zero, flag_carry, flag_dbz, flag_illegal}, ef);
            end
            n_cmp++;
            if (lat != elat || rdy_bad) begin
                n_err++; $display("FAIL rnd_timing: op=%0d latency %0d required %0d in_ready_busy=%0d required 0",
                                  ro, lat, elat, rdy_bad);
            end
            finish_op();
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_err++; $display("FAIL rnd_release: out_valid,in_ready=%b required 01", {out_valid, in_ready});
            end
        end
    endtask

    task automatic test_hold();
        logic [2*W-1:0] er;
        logic [3:0]     ef;
        int             elat, lat;
        bit             rdy_bad;
        model(8'd200, 8'd200, 3'd2, er, ef, elat);
        start_op(8'd200, 8'd200, 3'd2, 1'b1, lat, rdy_bad);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); op = 3'($urandom); in_valid = 1'b1;
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b10 || result !== er ||
                {flag_zero, flag_carry, flag_dbz, flag_illegal} !== ef) begin
                n_err++; $display("FAIL hold[%0d]: out_valid,in_ready=%b result=%h flags=%b required 10 %h %b",
                                  i, {out_valid, in_ready}, result,
                                  {flag_zero, flag_carry, flag_dbz, flag_illegal}, er, ef);
            end
        end
        finish_op();
    endtask

    task automatic test_reset_mid_div();
        logic [2*W-1:0] er;
        logic [3:0]     ef;
        int             elat, lat;
        bit             rdy_bad, seen;
        @(negedge clk);
        a = 8'd200; b = 8'd7; op = 3'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL middiv_busy: out_valid,in_ready=%b required 00", {out_valid, in_ready});
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01 || result !== '0 ||
            {flag_zero, flag_carry, flag_dbz, flag_illegal} !== 4'b0) begin
            n_err++; $display("FAIL middiv_reset: out_valid,in_ready=%b result=%h flags=%b required 01 0000 0000",
                              {out_valid, in_ready}, result, {flag_zero, flag_carry, flag_dbz, flag_illegal});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++; $display("FAIL middiv_abort: out_valid got 1 after reset required 0");
        end
        model(8'h21, 8'h43, 3'd0, er, ef, elat);
        start_op(8'h21, 8'h43, 3'd0, 1'b0, lat, rdy_bad);
        n_cmp++;
        if (result !== er || lat != elat) begin
            n_err++; $display("FAIL post_reset_add: result=%h latency=%0d required %h %0d", result, lat, er, elat);
        end
        finish_op();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
